// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared ALU op codes, issue-stage FSM states and widths.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package alu_pkg;

   localparam int DW    = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   localparam logic [3:0] FN_NOP = 4'd0;
   localparam logic [3:0] FN_ADD = 4'd1;
   localparam logic [3:0] FN_SUB = 4'd2;
   localparam logic [3:0] FN_AND = 4'd3;
   localparam logic [3:0] FN_OR  = 4'd4;
   localparam logic [3:0] FN_XOR = 4'd5;
   localparam logic [3:0] FN_NOT = 4'd6;
   localparam logic [3:0] FN_SLA = 4'd7;
   localparam logic [3:0] FN_SRA = 4'd8;
   localparam logic [3:0] FN_SRL = 4'd9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      WB     = 2'd2,
      WB_ILL = 2'd3
   } state_t;

   function automatic logic is_legal_funct(input logic [3:0] funct);
      return (funct >= FN_ADD) && (funct <= FN_SRL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_2r1w                                                 |
// | Description : 2 async read / 1 sync write register file, r0 reads zero.   |
// |               ALU_ISSUE_DBG_EN adds a third (debug) async read port.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_2r1w #(
   parameter  int NREGS = 32,
   parameter  int DW    = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [AW-1:0] dbg_raddr,
   output logic [DW-1:0] dbg_rdata
`endif
);

   // Entry 0 has no storage; its reads are forced to zero below.
   logic [DW-1:0] r_mem [1:NREGS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         r_mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (raddr_a != '0) rdata_a = r_mem[raddr_a];
      if (raddr_b != '0) rdata_b = r_mem[raddr_b];
   end

`ifdef ALU_ISSUE_DBG_EN
   always_comb begin
      dbg_rdata = '0;
      if (dbg_raddr != '0) dbg_rdata = r_mem[dbg_raddr];
   end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_issue_rf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_rf                                                 |
// | Description : Operand fetch / writeback stage in front of a registered     |
// |               ALU, one instruction in flight. ALU_ISSUE_DBG_EN adds a      |
// |               debug register read port and a retired-instruction counter.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_issue_rf #(
   parameter  int NREGS = 32,
   parameter  int DW    = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rs,
   input  logic [AW-1:0] in_rt,
   input  logic [AW-1:0] in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [3:0]    in_funct,
   input  logic          in_use_imm,
   input  logic [15:0]   in_imm,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [4:0]    alu_shamt,
   output logic [3:0]    alu_funct,
   input  logic [DW-1:0] alu_res,
   output logic          done,
   output logic [AW-1:0] done_rd,
   output logic [DW-1:0] done_data,
   output logic          illegal
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic [31:0]   dbg_retired
`endif
);

   import alu_pkg::*;

   state_t        r_state;
   state_t        w_next;

   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [4:0]    r_shamt;
   logic [3:0]    r_funct;
   logic [AW-1:0] r_rd;

   logic          r_done;
   logic [AW-1:0] r_done_rd;
   logic [DW-1:0] r_done_data;

   logic [DW-1:0] w_rdata_a;
   logic [DW-1:0] w_rdata_b;
   logic [DW-1:0] w_imm_ext;
   logic          w_accept;
   logic          w_wb_we;

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_wb_we   = (r_state == WB);
   assign w_imm_ext = {{(DW-16){in_imm[15]}}, in_imm};

   // Write lands at the WB closing edge, so an IDLE read right after sees it.
   regfile_2r1w #(
      .NREGS (NREGS),
      .DW    (DW)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .raddr_a   (in_rs),
      .rdata_a   (w_rdata_a),
      .raddr_b   (in_rt),
      .rdata_b   (w_rdata_b),
      .we        (w_wb_we),
      .waddr     (r_rd),
      .wdata     (alu_res)
`ifdef ALU_ISSUE_DBG_EN
      ,
      .dbg_raddr (dbg_addr),
      .dbg_rdata (dbg_data)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_shamt <= '0;
         r_funct <= '0;
         r_rd    <= '0;
      end else if (w_accept) begin
         r_a     <= w_rdata_a;
         r_b     <= in_use_imm ? w_imm_ext : w_rdata_b;
         r_shamt <= in_shamt;
         r_funct <= in_funct;
         r_rd    <= in_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done      <= 1'b0;
         r_done_rd   <= '0;
         r_done_data <= '0;
      end else begin
         r_done <= w_wb_we;
         if (w_wb_we) begin
            r_done_rd   <= r_rd;
            r_done_data <= alu_res;
         end
      end
   end

   // funct is only presented during EXEC so the ALU holds its result otherwise.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      alu_funct = FN_NOP;
      illegal   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next = is_legal_funct(in_funct) ? EXEC : WB_ILL;
            end
         end
         EXEC: begin
            alu_funct = r_funct;
            w_next    = WB;
         end
         WB: begin
            w_next = IDLE;
         end
         WB_ILL: begin
            illegal = 1'b1;
            w_next  = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_shamt = r_shamt;
   assign done      = r_done;
   assign done_rd   = r_done_rd;
   assign done_data = r_done_data;

`ifdef ALU_ISSUE_DBG_EN
   logic [31:0] r_retired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired <= '0;
      end else if (r_done) begin
         r_retired <= r_retired + 32'd1;
      end
   end

   assign dbg_retired = r_retired;
`endif

endmodule
`default_nettype wire

// File: doc/alu_issue_rf.md
Name: alu_issue_rf

Overview:
- Operand-fetch / writeback stage directly upstream of the registered ALU.
- Accepts one decoded instruction at a time over a valid/ready handshake and reads a 32x32 register file.
- Drives the ALU's a/b/shamt/funct inputs and waits for the ALU's registered result, then writes it back to the destination register.
- Runs strictly one instruction in flight, so no hazard logic is needed.

Parameters:
- NREGS, 32, number of architectural registers; address width is clog2(NREGS) = 5.
- DW, 32, data width; must match the ALU.

Ports:
- clk  in  1  rising-edge clock shared with the ALU.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_rs  in  5  source register A.
- in_rt  in  5  source register B; ignored when in_use_imm=1.
- in_rd  in  5  destination register.
- in_shamt  in  5  shift amount, passed through to the ALU.
- in_funct  in  4  ALU op code.
- in_use_imm  in  1  1: operand B is the sign-extended immediate.
- in_imm  in  16  immediate.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_shamt  out  5  to ALU shamt.
- alu_funct  out  4  to ALU funct.
- alu_res  in  32  from ALU res.
- done  out  1  one-cycle pulse when an instruction retires.
- done_rd  out  5  retired destination register.
- done_data  out  32  retired result.
- illegal  out  1  one-cycle pulse when funct is not legal.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset effects: all registers become 0; state goes to IDLE; every output becomes 0 except in_ready. in_ready is 1 after reset release.
- Op codes: 1=ADD, 2=SUB, 3=AND, 4=OR, 5=XOR, 6=NOT, 7=SLA, 8=SRA, 9=SRL. Codes 0 and 10-15 are illegal.
- Register 0: reads always return 0; writes to it are discarded.
- Operand formation:
  - alu_a = R[rs].
  - alu_b = in_use_imm ? {{16{imm[15]}}, imm} : R[rt].
  - Operands are registered at acceptance and held until return to IDLE.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1 and alu_funct=0, so the ALU holds its result.
  - Accept when in_valid=1: latch fields and read operands.
  - Legal funct goes to EXEC; illegal funct goes to WB_ILL, a single cycle that pulses illegal and then returns to IDLE.
- EXEC:
  - alu_a, alu_b, alu_shamt and alu_funct are stable.
  - The ALU captures res at the closing edge of this cycle.
- WB:
  - alu_res is valid.
  - At the closing edge, R[rd] <= alu_res (unless rd=0).
  - done pulses in the cycle after WB, with done_rd and done_data registered.
  - WB returns to IDLE.
- Latency:
  - Accept edge to the register write is 2 cycles.
  - An instruction accepted back-to-back in IDLE reads the just-written value, because the write lands before the IDLE read.
- Throughput: one instruction per 3 cycles.
- Illegal op: no ALU op is issued, there is no writeback, and done does not pulse.
- in_valid outside IDLE: ignored; the upstream holds the request until in_ready is seen.
- Shifts: shamt=0 is passed through unchanged; the ALU then shifts by b[0].
- Reset mid-operation: the instruction is abandoned with no writeback, and no done or illegal pulse.
- Undriven funct: alu_funct returns to 0 in IDLE and during WB.

Optional Feature:
- Macro: ALU_ISSUE_DBG_EN.
- When defined:
  - Adds dbg_addr (in, 5) and dbg_data (out, 32).
  - dbg_data is a combinational read of R[dbg_addr]; address 0 reads 0.
  - Also adds a 32-bit retired-instruction counter, cleared by reset, incremented on each done pulse, exposed as dbg_retired.
- When undefined: these ports and the counter are absent; functional behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - funct localparams FN_ADD..FN_SRL (1..9) and FN_NOP=0;
  - an is_legal_funct function;
  - state encoding IDLE/EXEC/WB/WB_ILL;
  - DW and register address width.
- One sub-module, regfile_2r1w: 2 async read ports, 1 sync write port, reset-to-zero, r0 hardwired to 0.

Test Plan:
- Immediate add: reset, then R1 = 0 + imm 5 (rs=0, use_imm, funct=1, rd=1) -> done 3 cycles after accept, done_rd=1, done_data=5.
- Dependent subtract: R2 = R1 - imm 0xFFFF (-1), issued immediately after the previous instruction -> done_data=6, confirming the fresh read-after-write.
- Arithmetic shift: R3 = imm 0x8000 (0xFFFF8000), then SRA with shamt=4 into R4 -> done_data=0xFFFFF800; SRL into R5 -> 0x0FFFF800.
- Illegal op: funct=12 -> illegal pulses once the cycle after accept, no done, R[rd] unchanged, in_ready back high after 2 cycles.
- Write to r0: rd=0, ADD imm 7 -> done_data=7, a later read of R0 gives 0.
- Reset during EXEC: no done, destination unchanged, in_ready=1 immediately after reset.
